// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared definitions for the branch target buffer:
//   - cnt_e     : 2-bit saturating direction counter encodings
//   - idx_width : number of index bits needed to address N entries
// No ports (package).
// -----------------------------------------------------------------------------
package bpred_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,  // strongly not-taken
        CNT_WNT = 2'd1,  // weakly not-taken
        CNT_WT  = 2'd2,  // weakly taken
        CNT_ST  = 2'd3   // strongly taken
    } cnt_e;

    // Smallest w with 2**w >= entries; entries is a power of two >= 2.
    function automatic int idx_width(input int entries);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < entries) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bpred_btb_if.sv
// -----------------------------------------------------------------------------
// bpred_btb_if
// Bundles the fetch-stage lookup and execute-stage update signals of the BTB.
//   Fetch   : PCF (to BTB), PredTakenF / PredPCF (from BTB)
//   Execute : UpdateE, PCE, TakenE, TargetE, PredTakenE, PredPCE (to BTB),
//             MispredictE (from BTB)
// Modports: master = pipeline side, slave = predictor side.
// -----------------------------------------------------------------------------
interface bpred_btb_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] PredPCF;

    logic            UpdateE;
    logic [XLEN-1:0] PCE;
    logic            TakenE;
    logic [XLEN-1:0] TargetE;
    logic            PredTakenE;
    logic [XLEN-1:0] PredPCE;
    logic            MispredictE;

    modport master (
        output PCF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredPCE,
        input  PredTakenF, PredPCF, MispredictE
    );

    modport slave (
        input  PCF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredPCE,
        output PredTakenF, PredPCF, MispredictE
    );

endinterface

// File: rtl/bpred_btb_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
// 2-bit saturating up/down counter with synchronous load, one per BTB entry.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (counter -> WNT)
//   en_i, up_i   : count enable and direction (1 = towards strongly taken)
//   load_i       : load load_val_i (wins over counting)
//   load_val_i   : value used on allocation
//   cnt_o        : current counter state
// -----------------------------------------------------------------------------
module sat_counter2
    import bpred_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic up_i,
    input  logic load_i,
    input  cnt_e load_val_i,
    output cnt_e cnt_o
);

    cnt_e cnt_q;
    cnt_e cnt_d;

    // Next-state: load has priority, otherwise saturate at SNT/ST.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                case (cnt_q)
                    CNT_SNT: cnt_d = CNT_WNT;
                    CNT_WNT: cnt_d = CNT_WT;
                    CNT_WT:  cnt_d = CNT_ST;
                    CNT_ST:  cnt_d = CNT_ST;
                    default: cnt_d = cnt_q;
                endcase
            end else begin
                case (cnt_q)
                    CNT_SNT: cnt_d = CNT_SNT;
                    CNT_WNT: cnt_d = CNT_SNT;
                    CNT_WT:  cnt_d = CNT_WNT;
                    CNT_ST:  cnt_d = CNT_WT;
                    default: cnt_d = cnt_q;
                endcase
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; reset discards any same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_WNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bpred_btb.sv
// -----------------------------------------------------------------------------
// bpred_btb
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup (fetch) is combinational; update (execute) commits on the next edge,
// so a same-cycle lookup of the updated index sees the old contents.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (valid bits clear, counters -> WNT)
//   btb   : bpred_btb_if.slave (lookup, update, mispredict)
// Parameters: XLEN (PC width), ENTRIES (power of two >= 2), TAG_W.
// Build option: define BPRED_TAG_EN to store/compare tags PC[IDX+TAG_W+1:IDX+2];
// without it an entry hits whenever it is valid (aliasing allowed).
// -----------------------------------------------------------------------------
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    bpred_btb_if.slave  btb
);

    localparam int              IDX     = idx_width(ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic [ENTRIES-1:0] valid_q;
    logic [XLEN-1:0]    target_q [ENTRIES];
    cnt_e               cnt_s    [ENTRIES];

    logic [IDX-1:0]     idx_f_s;
    logic [IDX-1:0]     idx_e_s;
    logic               hit_f_s;
    logic               hit_e_s;
    logic               alloc_s;
    logic               train_s;
    logic               pred_taken_s;
    logic [XLEN-1:0]    pred_pc_s;
    logic               mispredict_s;
    logic               unused_pc_s;

    assign idx_f_s = btb.PCF[IDX+1:2];
    assign idx_e_s = btb.PCE[IDX+1:2];

`ifdef BPRED_TAG_EN
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] tag_f_s;
    logic [TAG_W-1:0] tag_e_s;

    assign tag_f_s = btb.PCF[IDX+TAG_W+1:IDX+2];
    assign tag_e_s = btb.PCE[IDX+TAG_W+1:IDX+2];
    assign hit_f_s = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
    assign hit_e_s = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);

    // Tag written on allocation only; a hit already holds the matching tag.
    always_ff @(posedge clk) begin
        if (!reset && alloc_s) begin
            tag_q[idx_e_s] <= tag_e_s;
        end
    end
`else
    localparam int TAG_W_UNUSED = TAG_W;

    assign hit_f_s = valid_q[idx_f_s];
    assign hit_e_s = valid_q[idx_e_s];
`endif

    // Low PC bits and bits above the tag never select or identify an entry.
    assign unused_pc_s = ^{btb.PCF, btb.PCE};

    assign train_s = btb.UpdateE && hit_e_s;
    assign alloc_s = btb.UpdateE && !hit_e_s && btb.TakenE;

    // Fetch lookup: predict taken only on a hit with counter in a taken state.
    always_comb begin
        pred_taken_s = hit_f_s && cnt_s[idx_f_s][1];
        if (pred_taken_s) begin
            pred_pc_s = target_q[idx_f_s];
        end else begin
            pred_pc_s = btb.PCF + PC_STEP;
        end
    end

    // Redirect when direction was wrong, or taken with a wrong predicted target.
    always_comb begin
        mispredict_s = 1'b0;
        if (btb.UpdateE) begin
            mispredict_s = (btb.PredTakenE != btb.TakenE) ||
                           (btb.TakenE && (btb.PredPCE != btb.TargetE));
        end else begin
            mispredict_s = 1'b0;
        end
    end

    assign btb.PredTakenF  = pred_taken_s;
    assign btb.PredPCF     = pred_pc_s;
    assign btb.MispredictE = mispredict_s;

    // Valid bits: cleared by reset, set on allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (alloc_s) begin
            valid_q[idx_e_s] <= 1'b1;
        end
    end

    // Targets: refreshed on a taken hit or written on allocation.
    always_ff @(posedge clk) begin
        if (!reset && (alloc_s || (train_s && btb.TakenE))) begin
            target_q[idx_e_s] <= btb.TargetE;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel_s;
        assign sel_s = (idx_e_s == IDX'(i));

        sat_counter2 u_cnt (
            .clk        (clk),
            .reset      (reset),
            .en_i       (train_s && sel_s),
            .up_i       (btb.TakenE),
            .load_i     (alloc_s && sel_s),
            .load_val_i (CNT_WT),
            .cnt_o      (cnt_s[i])
        );
    end

endmodule
